// File: rtl/rv32i_ctrl_fsm.sv
// rv32i_ctrl_fsm: multi-cycle RV32I control FSM; define CTRL_ILLEGAL_TRAP_EN to make TRAP absorbing
module rv32i_ctrl_fsm #(
  parameter int RESET_BOOT_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       imem_ready,
  input  logic       dmem_ready,
  input  logic       br_taken,
  output logic       imem_req,
  output logic       ir_we,
  output logic       pc_we,
  output logic [1:0] pc_sel,
  output logic       alu_src_a,
  output logic       alu_src_b,
  output logic [3:0] alu_op,
  output logic [2:0] imm_sel,
  output logic       dmem_req,
  output logic       dmem_we,
  output logic       reg_we,
  output logic [1:0] wb_sel,
  output logic       illegal,
  output logic [2:0] state
);
  typedef enum logic [2:0] {S_BOOT, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP} state_t;
  state_t state_q, state_d;
  logic [3:0] boot_cnt_q, boot_cnt_d;
  logic is_r, is_opi, is_ld, is_st, is_br, is_jal, is_jalr, is_lui, is_auipc, is_fence;
  logic alt, legal_op, alu_ok, exe_a, exe_b;
  logic [3:0] f3_op, exe_op;
  logic [2:0] dec_imm;
  always_comb begin
    is_r = opcode == 7'b0110011;
    is_opi = opcode == 7'b0010011;
    is_ld = opcode == 7'b0000011;
    is_st = opcode == 7'b0100011;
    is_br = opcode == 7'b1100011;
    is_jal = opcode == 7'b1101111;
    is_jalr = opcode == 7'b1100111;
    is_lui = opcode == 7'b0110111;
    is_auipc = opcode == 7'b0010111;
    is_fence = opcode == 7'b0001111;
    alt = funct7 == 7'b0100000;
    legal_op = is_r | is_opi | is_ld | is_st | is_br | is_jal | is_jalr | is_lui | is_auipc | is_fence;
    alu_ok = is_r ? (funct7 == 7'd0 || (alt && (funct3 == 3'd0 || funct3 == 3'd5)))
           : (is_opi && funct3 == 3'd1) ? funct7 == 7'd0
           : (is_opi && funct3 == 3'd5) ? (funct7 == 7'd0 || alt) : 1'b1;
    f3_op = funct3 == 3'd0 ? {3'd0, is_r & alt} : funct3 == 3'd1 ? 4'd2 : funct3 == 3'd2 ? 4'd3
          : funct3 == 3'd3 ? 4'd4 : funct3 == 3'd4 ? 4'd5 : funct3 == 3'd5 ? (alt ? 4'd7 : 4'd6)
          : funct3 == 3'd6 ? 4'd8 : 4'd9;
    exe_op = !alu_ok ? 4'd0 : (is_r | is_opi) ? f3_op : is_lui ? 4'd10 : 4'd0;
    exe_a = alu_ok & is_auipc;
    exe_b = alu_ok & (is_opi | is_ld | is_st | is_lui | is_auipc);
    dec_imm = is_st ? 3'd1 : is_br ? 3'd2 : (is_lui | is_auipc) ? 3'd3 : is_jal ? 3'd4 : 3'd0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_BOOT;
      boot_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      boot_cnt_q <= boot_cnt_d;
    end
  end
  always_comb begin
    state_d = state_q;
    boot_cnt_d = boot_cnt_q;
    imem_req = 1'b0;
    ir_we = 1'b0;
    pc_we = 1'b0;
    pc_sel = 2'd0;
    alu_src_a = 1'b0;
    alu_src_b = 1'b0;
    alu_op = 4'd0;
    imm_sel = 3'd0;
    dmem_req = 1'b0;
    dmem_we = 1'b0;
    reg_we = 1'b0;
    wb_sel = 2'd0;
    illegal = 1'b0;
    case (state_q)
      S_BOOT: begin
        boot_cnt_d = boot_cnt_q + 4'd1;
        if (boot_cnt_q == 4'(RESET_BOOT_CYCLES - 1)) state_d = S_FETCH;
      end
      S_FETCH: begin
        imem_req = 1'b1;
        ir_we = imem_ready;
        if (imem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        imm_sel = dec_imm;
        state_d = legal_op ? S_EXEC : S_TRAP;
      end
      S_EXEC: begin
        alu_op = exe_op;
        alu_src_a = exe_a;
        alu_src_b = exe_b;
        pc_we = is_br | is_fence;
        pc_sel = {1'b0, is_br & br_taken};
        state_d = !alu_ok ? S_TRAP : (is_br | is_fence) ? S_FETCH : (is_ld | is_st) ? S_MEM : S_WB;
      end
      S_MEM: begin
        alu_op = exe_op;
        alu_src_a = exe_a;
        alu_src_b = exe_b;
        dmem_req = 1'b1;
        dmem_we = is_st;
        pc_we = is_st & dmem_ready;
        if (dmem_ready) state_d = is_st ? S_FETCH : S_WB;
      end
      S_WB: begin
        alu_op = exe_op;
        alu_src_a = exe_a;
        alu_src_b = exe_b;
        reg_we = 1'b1;
        pc_we = 1'b1;
        wb_sel = is_ld ? 2'd1 : (is_jal | is_jalr) ? 2'd2 : 2'd0;
        pc_sel = is_jal ? 2'd1 : is_jalr ? 2'd2 : 2'd0;
        state_d = S_FETCH;
      end
      S_TRAP: begin
        illegal = 1'b1;
`ifdef CTRL_ILLEGAL_TRAP_EN
        state_d = S_TRAP;
`else
        pc_we = 1'b1;
        state_d = S_FETCH;
`endif
      end
      default: state_d = S_BOOT;
    endcase
  end
  assign state = state_q;
endmodule
